// File: rtl/ctx_switch_ctrl.sv
// ctx_switch_ctrl: defers timer/external irqs to a safe retire boundary, switches to the kernel vector, resumes on ERET.
// Optional external irq source enabled by defining IRQ_EXT_EN.
module ctx_switch_ctrl #(
   parameter int                  PC_WIDTH    = 32,
   parameter logic [PC_WIDTH-1:0] VECTOR_ADDR = '0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                irq_timer,
   input  logic                irq_ext,
   input  logic                isUser,
   input  logic                instr_valid,
   input  logic [5:0]          opcode,
   input  logic [PC_WIDTH-1:0] pc_next,
   input  logic                eret,
   output logic                take_int,
   output logic                resume,
   output logic [PC_WIDTH-1:0] redirect_pc,
   output logic [PC_WIDTH-1:0] epc,
   output logic [1:0]          cause,
   output logic                wd_clear,
   output logic                in_kernel
);
   typedef enum logic [2:0] {IDLE, WAIT, SWITCH, IN_KERNEL, RESUME} state_t;
   state_t              state_q, state_d;
   logic                pend_t_q, pend_t_d, pend_e_q, pend_e_d;
   logic [PC_WIDTH-1:0] epc_q, epc_d;
   logic [1:0]          cause_q, cause_d;
   logic                jump, boundary;
`ifndef IRQ_EXT_EN
   logic unused_irq_ext;
   assign unused_irq_ext = irq_ext;
`endif
   always_comb begin
      jump     = opcode inside {6'b010010, 6'b010101, 6'b111100, 6'b111101, 6'b111110};
      boundary = instr_valid & !jump & !eret;
      state_d  = state_q;
      epc_d    = epc_q;
      cause_d  = cause_q;
      pend_t_d = pend_t_q | irq_timer;
`ifdef IRQ_EXT_EN
      pend_e_d = pend_e_q | irq_ext;
`else
      pend_e_d = 1'b0;
`endif
      case (state_q)
         IDLE:      if (isUser & (pend_t_q | pend_e_q)) state_d = WAIT;
         WAIT:
            if (!isUser) state_d = IDLE;
            else if (boundary) begin
               epc_d   = pc_next;
               cause_d = {pend_e_q, pend_t_q};
               state_d = SWITCH;
            end
         SWITCH: begin
            // clear beats a same-cycle request; a held level re-latches next cycle
            pend_t_d = 1'b0;
            pend_e_d = 1'b0;
            state_d  = IN_KERNEL;
         end
         IN_KERNEL: if (instr_valid & eret) state_d = RESUME;
         RESUME:    state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         pend_t_q <= 1'b0;
         pend_e_q <= 1'b0;
         epc_q    <= '0;
         cause_q  <= '0;
      end else begin
         state_q  <= state_d;
         pend_t_q <= pend_t_d;
         pend_e_q <= pend_e_d;
         epc_q    <= epc_d;
         cause_q  <= cause_d;
      end
   end
   assign take_int    = state_q == SWITCH;
   assign wd_clear    = take_int;
   assign resume      = state_q == RESUME;
   assign in_kernel   = state_q == IN_KERNEL;
   assign redirect_pc = take_int ? VECTOR_ADDR : resume ? epc_q : '0;
   assign epc         = epc_q;
   assign cause       = cause_q;
endmodule

// File: tb/tb_ctx_switch_ctrl.sv
// tb_ctx_switch_ctrl: directed scenarios plus random traffic against a rule-level reference model.
module tb_ctx_switch_ctrl;
   logic        clk = 1'b0;
   logic        reset, irq_timer, irq_ext, isUser, instr_valid, eret;
   logic [5:0]  opcode;
   logic [31:0] pc_next;
   logic        take_int, resume, wd_clear, in_kernel;
   logic [31:0] redirect_pc, epc;
   logic [1:0]  cause;
`ifdef IRQ_EXT_EN
   localparam bit EXT = 1'b1;
`else
   localparam bit EXT = 1'b0;
`endif
   localparam int M_IDLE = 0, M_WAIT = 1, M_SW = 2, M_KERN = 3, M_RES = 4;
   localparam logic [5:0] ADD = 6'b000001, J = 6'b111100, JAL = 6'b111110, JR = 6'b010010;
   int          n_chk = 0, n_pass = 0;
   int          m_mode;
   bit          m_pt, m_pe;
   logic [31:0] m_epc;
   logic [1:0]  m_cause;

   ctx_switch_ctrl dut (
      .clk(clk), .reset(reset), .irq_timer(irq_timer), .irq_ext(irq_ext), .isUser(isUser),
      .instr_valid(instr_valid), .opcode(opcode), .pc_next(pc_next), .eret(eret),
      .take_int(take_int), .resume(resume), .redirect_pc(redirect_pc), .epc(epc),
      .cause(cause), .wd_clear(wd_clear), .in_kernel(in_kernel)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
   endtask

   function automatic bit is_jump(input logic [5:0] op);
      return op inside {6'b010010, 6'b010101, 6'b111100, 6'b111101, 6'b111110};
   endfunction

   task automatic step();
      bit npt, npe;
      @(posedge clk);
      if (reset) begin
         m_mode = M_IDLE; m_pt = 0; m_pe = 0; m_epc = 0; m_cause = 0;
      end else begin
         npt = m_pt | irq_timer;
         npe = EXT & (m_pe | irq_ext);
         case (m_mode)
            M_IDLE: if (isUser && (m_pt || m_pe)) m_mode = M_WAIT;
            M_WAIT:
               if (!isUser) m_mode = M_IDLE;
               else if (instr_valid && !is_jump(opcode) && !eret) begin
                  m_epc = pc_next; m_cause = {m_pe, m_pt}; m_mode = M_SW;
               end
            M_SW: begin npt = 0; npe = 0; m_mode = M_KERN; end
            M_KERN: if (instr_valid && eret) m_mode = M_RES;
            default: m_mode = M_IDLE;
         endcase
         m_pt = npt; m_pe = npe;
      end
      #1;
      check("take_int", take_int, m_mode == M_SW);
      check("wd_clear", wd_clear, m_mode == M_SW);
      check("resume", resume, m_mode == M_RES);
      check("in_kernel", in_kernel, m_mode == M_KERN);
      check("redirect_pc", redirect_pc, m_mode == M_RES ? m_epc : 32'h0);
      check("epc", epc, m_epc);
      check("cause", cause, m_cause);
   endtask

   task automatic cyc(input bit r, input bit it, input bit ie, input bit u, input bit v, input bit er,
                      input logic [5:0] op, input logic [31:0] pc);
      @(negedge clk);
      reset = r; irq_timer = it; irq_ext = ie; isUser = u; instr_valid = v; eret = er;
      opcode = op; pc_next = pc;
      step();
   endtask

   initial begin
      logic [5:0] op;
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      check("rst_take_int", take_int, 0);
      // basic preemption
      cyc(0, 1, 0, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 1, 0, ADD, 32'h40);
      check("t1_take_int", take_int, 1);
      check("t1_epc", epc, 32'h40);
      check("t1_cause", cause, 2'b01);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 1, 0, 0);
      check("t1_resume", resume, 1);
      cyc(0, 0, 0, 1, 0, 0, 0, 0);
      // jumps are never a boundary
      cyc(0, 1, 0, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 1, 0, J, 32'h10);
      cyc(0, 0, 0, 1, 1, 0, JAL, 32'h20);
      cyc(0, 0, 0, 1, 1, 0, JR, 32'h30);
      cyc(0, 0, 0, 1, 1, 0, ADD, 32'h88);
      check("t2_take_int", take_int, 1);
      check("t2_epc", epc, 32'h88);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      // irq held in kernel is deferred until after ERET
      repeat (3) cyc(0, 1, 0, 0, 1, 0, ADD, 32'h5);
      cyc(0, 1, 0, 0, 1, 1, 0, 0);
      check("t3_resume", resume, 1);
      check("t3_redirect", redirect_pc, 32'h88);
      cyc(0, 0, 0, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 1, 0, ADD, 32'h100);
      check("t3_take_int", take_int, 1);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 1, 0, 0);
      // kernel-mode requests stay pending
      repeat (20) cyc(0, 1, 0, 0, 1, 0, ADD, 32'h7);
      cyc(0, 0, 0, 1, 1, 0, ADD, 32'h200);
      cyc(0, 0, 0, 1, 1, 0, ADD, 32'h204);
      check("t4_take_int", take_int, 1);
      check("t4_epc", epc, 32'h204);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 1, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0, 0);
      // reset mid-WAIT
      cyc(0, 1, 0, 1, 0, 0, 0, 0);
      cyc(0, 1, 0, 1, 0, 0, 0, 0);
      cyc(1, 1, 0, 1, 1, 0, ADD, 32'h300);
      check("t5_take_int", take_int, 0);
      check("t5_epc", epc, 0);
      cyc(0, 1, 0, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 1, 0, ADD, 32'h400);
      check("t5_take_int2", take_int, 1);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 1, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0, 0);
      // external irq alone, and together with timer
      cyc(0, 0, 1, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 1, 0, ADD, 32'h500);
      check("t6_take_int", take_int, EXT);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 1, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0, 0);
      cyc(0, 1, 1, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 1, 0, ADD, 32'h600);
      check("t6_cause", cause, {EXT, 1'b1});
      // random traffic
      for (int i = 0; i < 3000; i++) begin
         case ($urandom_range(0, 3))
            0: op = JR;
            1: op = $urandom_range(0, 1) ? J : JAL;
            default: op = 6'($urandom);
         endcase
         cyc($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 15,
             $urandom_range(0, 99) < 85, $urandom_range(0, 1), $urandom_range(0, 99) < 25, op, $urandom);
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
